// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types and round-robin pick helper for stream_mux_4x1
package stream_mux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scans ptr+1, ptr+2, ptr+3, ptr (mod 4); the first requester wins.
  function automatic pick_t rr_pick(input logic [N_CH-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] cand;
    p = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = ptr + k[SEL_W-1:0];
      if (!p.valid && req[cand]) begin
        p.valid = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/stream_mux_4x1_if.sv
// rtl/stream_mux_4x1_if.sv - four input streams plus one merged output stream
interface stream_mux_4x1_if #(
  parameter int DATA_W = 8
);
  import stream_mux_pkg::*;

  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic                   out_last;
  logic [SEL_W-1:0]       out_sel;

  // master drives the producer inputs and consumes the output; slave is the mux itself
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );

endinterface

// File: rtl/stream_mux_4x1_rr_arbiter.sv
// rtl/stream_mux_4x1_rr_arbiter.sv - combinational 4-way round-robin arbiter with lock override
module rr_arbiter_4
  import stream_mux_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             lock_en,
  input  logic [SEL_W-1:0] lock_idx,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any_grant
);

  pick_t pick;

  always_comb begin
    pick = '0;
    if (lock_en) begin
      // a locked packet owner is the only candidate, even if it is not requesting
      pick.valid = req[lock_idx];
      pick.idx   = lock_idx;
    end else begin
      pick = rr_pick(req, ptr);
    end
  end

  assign any_grant = pick.valid;
  assign grant_idx = pick.idx;
  assign grant     = pick.valid ? (N_CH'(1) << pick.idx) : '0;

endmodule

// File: rtl/stream_mux_4x1.sv
// rtl/stream_mux_4x1.sv - 4:1 round-robin stream merger with optional packet lock
module stream_mux_4x1
  import stream_mux_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter bit LOCK_PKT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  stream_mux_4x1_if.slave bus
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  lock_idx_q, lock_idx_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic [SEL_W-1:0]  out_sel_q;

  logic [N_CH-1:0]   grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              any_grant;
  logic              can_load;
  logic              xfer;
  logic              beat_last;
  logic [DATA_W-1:0] beat_data;

  rr_arbiter_4 u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .lock_en   (state_q == LOCKED),
    .lock_idx  (lock_idx_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // the output register frees up in the same cycle the consumer takes the held beat
  assign can_load  = !out_valid_q || bus.out_ready;
  assign xfer      = any_grant && can_load && !rst;
  assign beat_last = bus.in_last[grant_idx];
  assign beat_data = bus.in_data[grant_idx*DATA_W +: DATA_W];

  assign bus.in_ready  = xfer ? grant : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    if (xfer) begin
      ptr_d = grant_idx;
      case (state_q)
        ARB: begin
          if (LOCK_PKT && !beat_last) begin
            state_d    = LOCKED;
            lock_idx_d = grant_idx;
          end
        end
        LOCKED: begin
          if (beat_last) begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      lock_idx_q <= '0;
      ptr_q      <= SEL_W'(N_CH - 1);
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= beat_data;
      out_last_q  <= beat_last;
      out_sel_q   <= grant_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_4x1.sv
// tb/tb_stream_mux_4x1.sv - directed vector bench for stream_mux_4x1 in both lock modes
module tb_stream_mux_4x1;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  stream_mux_4x1_if #(.DATA_W(8)) if0 ();
  stream_mux_4x1_if #(.DATA_W(8)) if1 ();

  stream_mux_4x1 #(.DATA_W(8), .LOCK_PKT(1'b0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  stream_mux_4x1 #(.DATA_W(8), .LOCK_PKT(1'b1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_os;
    logic        exp_ol;
    logic        chk_fields;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // inputs applied one unit after an edge, in_ready checked before the next edge, outputs after it
  task automatic run_vec(input int dut, input int idx, input vec_t v);
    if (dut == 0) begin
      rst0 = v.rst; if0.in_valid = v.valid; if0.in_last = v.last;
      if0.in_data = v.data; if0.out_ready = v.ordy;
    end else begin
      rst1 = v.rst; if1.in_valid = v.valid; if1.in_last = v.last;
      if1.in_data = v.data; if1.out_ready = v.ordy;
    end
    #2;
    chk(dut == 0 ? "d0_in_ready" : "d1_in_ready", idx, 32'(dut == 0 ? if0.in_ready : if1.in_ready), 32'(v.exp_ir));
    @(posedge clk);
    #1;
    chk(dut == 0 ? "d0_out_valid" : "d1_out_valid", idx, 32'(dut == 0 ? if0.out_valid : if1.out_valid), 32'(v.exp_ov));
    if (v.chk_fields) begin
      chk(dut == 0 ? "d0_out_data" : "d1_out_data", idx, 32'(dut == 0 ? if0.out_data : if1.out_data), 32'(v.exp_od));
      chk(dut == 0 ? "d0_out_sel" : "d1_out_sel", idx, 32'(dut == 0 ? if0.out_sel : if1.out_sel), 32'(v.exp_os));
      chk(dut == 0 ? "d0_out_last" : "d1_out_last", idx, 32'(dut == 0 ? if0.out_last : if1.out_last), 32'(v.exp_ol));
    end
  endtask

  vec_t t0 [15];

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    if0.in_valid = '0; if0.in_last = '0; if0.in_data = '0; if0.out_ready = 1'b0;
    if1.in_valid = '0; if1.in_last = '0; if1.in_data = '0; if1.out_ready = 1'b0;

    //          rst   valid    last     data          ordy  ir       ov    od     os    ol    chk
    t0[0]  = '{1'b1, 4'b1111, 4'b0101, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    t0[1]  = '{1'b1, 4'b1111, 4'b0101, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    t0[2]  = '{1'b0, 4'b1111, 4'b0101, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1, 1'b1};
    t0[3]  = '{1'b0, 4'b1111, 4'b0101, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b0, 1'b1};
    t0[4]  = '{1'b0, 4'b1111, 4'b0101, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1, 1'b1};
    t0[5]  = '{1'b0, 4'b1111, 4'b0101, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b0, 1'b1};
    t0[6]  = '{1'b0, 4'b1111, 4'b0101, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1, 1'b1};
    t0[7]  = '{1'b0, 4'b0100, 4'b0101, 32'hA35CA1A0, 1'b1, 4'b0100, 1'b1, 8'h5C, 2'd2, 1'b1, 1'b1};
    t0[8]  = '{1'b0, 4'b0100, 4'b0101, 32'hA35CA1A0, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd2, 1'b1, 1'b1};
    t0[9]  = '{1'b0, 4'b0100, 4'b0101, 32'hA35CA1A0, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd2, 1'b1, 1'b1};
    t0[10] = '{1'b0, 4'b0100, 4'b0101, 32'hA35CA1A0, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd2, 1'b1, 1'b1};
    t0[11] = '{1'b0, 4'b0101, 4'b0101, 32'hA35CA1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1, 1'b1};
    t0[12] = '{1'b0, 4'b0000, 4'b0101, 32'hA35CA1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    t0[13] = '{1'b0, 4'b0000, 4'b0101, 32'hA35CA1A0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    t0[14] = '{1'b0, 4'b1111, 4'b0101, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b0, 1'b1};

    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) run_vec(0, i, t0[i]);
    rst0 = 1'b1;

    // packet lock on channel 1 with channels 0 and 3 competing
    run_vec(1, 100, '{1'b1, 4'b1111, 4'b0000, 32'h33221100, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1});
    run_vec(1, 101, '{1'b1, 4'b1111, 4'b0000, 32'h33221100, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1});
    run_vec(1, 102, '{1'b0, 4'b0010, 4'b0000, 32'h33221100 | 32'h00001100, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b0, 1'b1});
    run_vec(1, 103, '{1'b0, 4'b1011, 4'b0000, 32'h33221200, 1'b1, 4'b0010, 1'b1, 8'h12, 2'd1, 1'b0, 1'b1});
    run_vec(1, 104, '{1'b0, 4'b1011, 4'b0010, 32'h33221300, 1'b1, 4'b0010, 1'b1, 8'h13, 2'd1, 1'b1, 1'b1});
    run_vec(1, 105, '{1'b0, 4'b1001, 4'b1000, 32'h33221300, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3, 1'b1, 1'b1});

    // second packet on channel 1 stalls for 4 cycles while channel 2 requests
    run_vec(1, 106, '{1'b0, 4'b0010, 4'b0000, 32'h33222100, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++)
      run_vec(1, 107 + i, '{1'b0, 4'b1101, 4'b0100, 32'h33222100, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
    run_vec(1, 111, '{1'b0, 4'b1111, 4'b0000, 32'h33222200, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b0, 1'b1});

    // reset while locked with a beat held; channel 0 must win afterwards
    run_vec(1, 112, '{1'b1, 4'b1111, 4'b0000, 32'h33222200, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1});
    run_vec(1, 113, '{1'b0, 4'b1111, 4'b0001, 32'h33222240, 1'b1, 4'b0001, 1'b1, 8'h40, 2'd0, 1'b1, 1'b1});
    run_vec(1, 114, '{1'b0, 4'b1111, 4'b0010, 32'h33222240, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
